exe_stage_ctrl: RTL and testbench

- Execute-stage pipeline controller. Latches the decoded bundle from ID, drives the ALU operand/op interface, and holds the stage while a multi-cycle divide completes.
- Issues the data-SRAM request for loads and stores, and hands the result to MEM over the valid/allowin handshake.
- Exports a forwarding/hazard bundle to ID.

---
 rtl/exe_stage_ctrl_pkg.sv | 49 ++++
 rtl/exe_stage_ctrl_store_align.sv | 34 +++
 rtl/exe_stage_ctrl.sv | 136 +++++++++++++
 tb/tb_exe_stage_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_stage_ctrl_pkg.sv
// Shared types for the execute-stage controller: bundle layouts, ALU op bits,
// memory access sizes and the divide FSM encoding.
package exe_stage_ctrl_pkg;

    localparam int DS_BUS_W = 155;
    localparam int ES_BUS_W = 73;
    localparam int ALU_OP_W = 16;

    localparam int OP_DIV = 14;
    localparam int OP_MOD = 15;

    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_WAIT = 2'd1,
        DIV_DONE = 2'd2,
        DRAIN    = 2'd3
    } es_state_e;

    // Field order matches the bus bit layout, MSB first.
    typedef struct packed {
        logic [31:0]         pc;
        logic [ALU_OP_W-1:0] alu_op;
        logic [31:0]         src1;
        logic [31:0]         src2;
        logic                src_is_signed;
        logic [4:0]          dest;
        logic                gr_we;
        logic                mem_we;
        logic                res_from_mem;
        mem_size_e           mem_size;
        logic [31:0]         rkd_value;
    } ds_bundle_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] result;
        logic [4:0]  dest;
        logic        gr_we;
        logic        res_from_mem;
        mem_size_e   mem_size;
    } es_bundle_t;

endpackage

// File: rtl/exe_stage_ctrl_store_align.sv
// Store lane steering: byte strobes and replicated write data for b/h/w stores.
module store_align
    import exe_stage_ctrl_pkg::*;
(
    input  logic        mem_we,
    input  mem_size_e   mem_size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rkd_value,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata
);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        wstrb = '0;
        wdata = rkd_value;
        case (mem_size)
            MEM_B: begin
                wstrb = 4'b0001 << addr_lo;
                wdata = {4{rkd_value[7:0]}};
            end
            MEM_H: begin
                wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{rkd_value[15:0]}};
            end
            MEM_W: wstrb = 4'b1111;
            default: wstrb = '0;
        endcase
        if (!mem_we) begin
            wstrb = '0;
        end
    end

endmodule

// File: rtl/exe_stage_ctrl.sv
// Execute-stage controller: holds the ID bundle, sequences multi-cycle divides,
// issues data-SRAM requests and hands results to MEM.
module exe_stage_ctrl
    import exe_stage_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                ds_to_es_valid,
    output logic                es_allowin,
    input  logic [DS_BUS_W-1:0] ds_to_es_bus,
    input  logic                ms_allowin,
    output logic                es_to_ms_valid,
    output logic [ES_BUS_W-1:0] es_to_ms_bus,
    input  logic                flush,
    output logic                alu_valid,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [31:0]         alu_src1,
    output logic [31:0]         alu_src2,
    output logic                src_is_signed,
    input  logic [31:0]         alu_result,
    input  logic                divres_valid,
    output logic                data_sram_en,
    output logic [3:0]          data_sram_we,
    output logic [31:0]         data_sram_addr,
    output logic [31:0]         data_sram_wdata,
    output logic                es_fwd_valid,
    output logic [4:0]          es_fwd_dest,
    output logic [31:0]         es_fwd_result,
    output logic                es_fwd_is_load
);

    ds_bundle_t  bundle;
    es_bundle_t  es_out;
    es_state_e   state;
    logic        es_valid;
    logic [31:0] div_res;
    logic        is_div;
    logic        es_ready_go;
    logic [31:0] es_result;

    assign is_div      = bundle.alu_op[OP_DIV] | bundle.alu_op[OP_MOD];
    assign es_ready_go = !is_div || (state == DIV_DONE) || (state == DIV_WAIT && divres_valid);

    // DRAIN keeps ID out until the orphaned divide result has been swallowed.
    assign es_allowin     = (state != DRAIN) && (!es_valid || (es_ready_go && ms_allowin));
    assign es_to_ms_valid = es_valid && es_ready_go && !flush;
    assign alu_valid      = es_valid && is_div && (state == IDLE);
    assign es_result      = (state == DIV_DONE) ? div_res : alu_result;

    // NOTE: sequential state uses non-blocking assignments only; combinational
    // logic uses continuous assigns or always_comb with blocking assignments.
    always_ff @(posedge clk) begin
        if (reset) begin
            es_valid <= 1'b0;
            bundle   <= '0;
        end else begin
            if (flush) begin
                es_valid <= 1'b0;
            end else if (es_allowin) begin
                es_valid <= ds_to_es_valid;
            end
            if (ds_to_es_valid && es_allowin) begin
                bundle <= ds_bundle_t'(ds_to_es_bus);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            div_res <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (alu_valid) begin
                        state <= flush ? DRAIN : DIV_WAIT;
                    end
                end
                DIV_WAIT: begin
                    if (divres_valid) begin
                        if (flush || ms_allowin) begin
                            state <= IDLE;
                        end else begin
                            state   <= DIV_DONE;
                            div_res <= alu_result;
                        end
                    end else if (flush) begin
                        state <= DRAIN;
                    end
                end
                DIV_DONE: begin
                    if (flush || ms_allowin) begin
                        state <= IDLE;
                    end
                end
                DRAIN: begin
                    if (divres_valid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign alu_op        = bundle.alu_op;
    assign alu_src1      = bundle.src1;
    assign alu_src2      = bundle.src2;
    assign src_is_signed = bundle.src_is_signed;

    assign data_sram_en   = es_valid && (bundle.mem_we || bundle.res_from_mem) && ms_allowin && !flush;
    assign data_sram_addr = alu_result;

    store_align u_store_align (
        .mem_we    (bundle.mem_we),
        .mem_size  (bundle.mem_size),
        .addr_lo   (alu_result[1:0]),
        .rkd_value (bundle.rkd_value),
        .wstrb     (data_sram_we),
        .wdata     (data_sram_wdata)
    );

    assign es_out.pc           = bundle.pc;
    assign es_out.result       = es_result;
    assign es_out.dest         = bundle.dest;
    assign es_out.gr_we        = bundle.gr_we;
    assign es_out.res_from_mem = bundle.res_from_mem;
    assign es_out.mem_size     = bundle.mem_size;
    assign es_to_ms_bus        = es_out;

    assign es_fwd_valid   = es_valid && bundle.gr_we && (bundle.dest != 5'd0);
    assign es_fwd_dest    = bundle.dest;
    assign es_fwd_result  = es_result;
    assign es_fwd_is_load = bundle.res_from_mem || (is_div && !es_ready_go);

endmodule

// File: tb/tb_exe_stage_ctrl.sv
// Bench for exe_stage_ctrl: vector table for single-cycle ops plus directed
// divide/flush/reset sequences; a scoreboard checks every EXE->MEM handoff.
module tb_exe_stage_ctrl;

    localparam logic [15:0] OP_ADD = 16'h0001;
    localparam logic [15:0] OP_DIV = 16'h4000;
    localparam logic [15:0] OP_MOD = 16'h8000;

    logic         clk = 1'b0;
    logic         reset;
    logic         ds_to_es_valid;
    logic         es_allowin;
    logic [154:0] ds_to_es_bus;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [72:0]  es_to_ms_bus;
    logic         flush;
    logic         alu_valid;
    logic [15:0]  alu_op;
    logic [31:0]  alu_src1;
    logic [31:0]  alu_src2;
    logic         src_is_signed;
    logic [31:0]  alu_result;
    logic         divres_valid;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic         es_fwd_valid;
    logic [4:0]   es_fwd_dest;
    logic [31:0]  es_fwd_result;
    logic         es_fwd_is_load;

    int n_checks = 0;
    int n_errors = 0;
    logic [72:0] sb_q[$];

    always #5 clk = ~clk;

    exe_stage_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .ds_to_es_valid  (ds_to_es_valid),
        .es_allowin      (es_allowin),
        .ds_to_es_bus    (ds_to_es_bus),
        .ms_allowin      (ms_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .flush           (flush),
        .alu_valid       (alu_valid),
        .alu_op          (alu_op),
        .alu_src1        (alu_src1),
        .alu_src2        (alu_src2),
        .src_is_signed   (src_is_signed),
        .alu_result      (alu_result),
        .divres_valid    (divres_valid),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .es_fwd_valid    (es_fwd_valid),
        .es_fwd_dest     (es_fwd_dest),
        .es_fwd_result   (es_fwd_result),
        .es_fwd_is_load  (es_fwd_is_load)
    );

    task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [154:0] pack(input logic [31:0] pc, input logic [15:0] op,
                                          input logic [31:0] s1, input logic [31:0] s2,
                                          input logic sg, input logic [4:0] dest,
                                          input logic gw, input logic mw, input logic rfm,
                                          input logic [1:0] sz, input logic [31:0] rkd);
        return {pc, op, s1, s2, sg, dest, gw, mw, rfm, sz, rkd};
    endfunction

    function automatic logic [72:0] es_exp(input logic [31:0] pc, input logic [31:0] res,
                                           input logic [4:0] dest, input logic gw,
                                           input logic rfm, input logic [1:0] sz);
        return {pc, res, dest, gw, rfm, sz};
    endfunction

    // Scoreboard: every accepted handoff must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && es_to_ms_valid && ms_allowin) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_handoff", es_to_ms_valid, 1'b0);
            end else begin
                check("sb_bus", es_to_ms_bus, sb_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [15:0] op;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [4:0]  dest;
        logic        gr_we;
        logic        mem_we;
        logic        rfm;
        logic [1:0]  size;
        logic [31:0] rkd;
        logic        en;
        logic [3:0]  we;
        logic [31:0] wdata;
        logic        fwd_v;
        logic        fwd_ld;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int pulses;
        int low;
        logic [31:0] pc;
        logic [31:0] res;

        vecs[0] = '{"add",  OP_ADD, 32'd5,      32'd7,   5'd3, 1'b1, 1'b0, 1'b0, 2'b10, 32'h0,        1'b0, 4'b0000, 32'h0,        1'b1, 1'b0};
        vecs[1] = '{"st_b3", OP_ADD, 32'h1000,  32'd3,   5'd0, 1'b0, 1'b1, 1'b0, 2'b00, 32'h000000AB, 1'b1, 4'b1000, 32'hABABABAB, 1'b0, 1'b0};
        vecs[2] = '{"st_h2", OP_ADD, 32'h1000,  32'd2,   5'd0, 1'b0, 1'b1, 1'b0, 2'b01, 32'h12345678, 1'b1, 4'b1100, 32'h56785678, 1'b0, 1'b0};
        vecs[3] = '{"st_w",  OP_ADD, 32'h2000,  32'd0,   5'd0, 1'b0, 1'b1, 1'b0, 2'b10, 32'hDEADBEEF, 1'b1, 4'b1111, 32'hDEADBEEF, 1'b0, 1'b0};
        vecs[4] = '{"st_b1", OP_ADD, 32'h1000,  32'd1,   5'd0, 1'b0, 1'b1, 1'b0, 2'b00, 32'h12345699, 1'b1, 4'b0010, 32'h99999999, 1'b0, 1'b0};
        vecs[5] = '{"ld_w",  OP_ADD, 32'h3000,  32'd0,   5'd4, 1'b1, 1'b0, 1'b1, 2'b10, 32'h0,        1'b1, 4'b0000, 32'h0,        1'b1, 1'b1};
        vecs[6] = '{"add_r0", OP_ADD, 32'd9,    32'd1,   5'd0, 1'b1, 1'b0, 1'b0, 2'b10, 32'h0,        1'b0, 4'b0000, 32'h0,        1'b0, 1'b0};
        vecs[7] = '{"st_h0", OP_ADD, 32'h1000,  32'd0,   5'd0, 1'b0, 1'b1, 1'b0, 2'b01, 32'hCAFEBABE, 1'b1, 4'b0011, 32'hBABEBABE, 1'b0, 1'b0};

        reset          = 1'b1;
        ds_to_es_valid = 1'b0;
        ds_to_es_bus   = '0;
        ms_allowin     = 1'b1;
        flush          = 1'b0;
        alu_result     = '0;
        divres_valid   = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
        #2;
        check("rst_allowin",    es_allowin, 1'b1);
        check("rst_to_ms",      es_to_ms_valid, 1'b0);
        check("rst_bus",        es_to_ms_bus, '0);
        check("rst_alu_valid",  alu_valid, 1'b0);
        check("rst_alu_op",     alu_op, '0);
        check("rst_src1",       alu_src1, '0);
        check("rst_sram_en",    data_sram_en, 1'b0);
        check("rst_sram_we",    data_sram_we, '0);
        check("rst_sram_wdata", data_sram_wdata, '0);
        check("rst_fwd_valid",  es_fwd_valid, 1'b0);
        check("rst_fwd_load",   es_fwd_is_load, 1'b0);

        // Single-cycle ops; the bench plays the ALU (address/sum = src1 + src2).
        for (int i = 0; i < 8; i++) begin
            pc  = 32'h1c00_0000 + 32'(i * 4);
            res = vecs[i].s1 + vecs[i].s2;
            ds_to_es_valid = 1'b1;
            ds_to_es_bus   = pack(pc, vecs[i].op, vecs[i].s1, vecs[i].s2, 1'b0, vecs[i].dest,
                                  vecs[i].gr_we, vecs[i].mem_we, vecs[i].rfm, vecs[i].size, vecs[i].rkd);
            sb_q.push_back(es_exp(pc, res, vecs[i].dest, vecs[i].gr_we, vecs[i].rfm, vecs[i].size));
            cyc();
            ds_to_es_valid = 1'b0;
            alu_result     = res;
            #2;
            check({vecs[i].name, "_to_ms"},     es_to_ms_valid, 1'b1);
            check({vecs[i].name, "_allowin"},   es_allowin, 1'b1);
            check({vecs[i].name, "_alu_valid"}, alu_valid, 1'b0);
            check({vecs[i].name, "_src1"},      alu_src1, vecs[i].s1);
            check({vecs[i].name, "_src2"},      alu_src2, vecs[i].s2);
            check({vecs[i].name, "_en"},        data_sram_en, vecs[i].en);
            check({vecs[i].name, "_we"},        data_sram_we, vecs[i].we);
            check({vecs[i].name, "_wdata"},     data_sram_wdata, vecs[i].wdata);
            check({vecs[i].name, "_addr"},      data_sram_addr, res);
            check({vecs[i].name, "_fwd_v"},     es_fwd_valid, vecs[i].fwd_v);
            check({vecs[i].name, "_fwd_ld"},    es_fwd_is_load, vecs[i].fwd_ld);
            check({vecs[i].name, "_fwd_res"},   es_fwd_result, res);
            cyc();
            alu_result = '0;
            #2;
            check({vecs[i].name, "_en_drop"},   data_sram_en, 1'b0);
            check({vecs[i].name, "_idle"},      es_to_ms_valid, 1'b0);
        end

        // Signed divide -7 / 2 = -3, result after 10 cycles.
        cyc();
        pc = 32'h1c00_0100;
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = pack(pc, OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 2'b10, 32'h0);
        sb_q.push_back(es_exp(pc, 32'hFFFF_FFFD, 5'd5, 1'b1, 1'b0, 2'b10));
        cyc();
        ds_to_es_valid = 1'b0;
        alu_result     = 32'h1234_5678;
        pulses = 0;
        low    = 0;
        for (int k = 0; k < 10; k++) begin
            #2;
            pulses += int'(alu_valid);
            low    += int'(!es_allowin);
            check("div_wait_no_handoff", es_to_ms_valid, 1'b0);
            check("div_wait_fwd_ld", es_fwd_is_load, 1'b1);
            if (k == 0) begin
                check("div_src1", alu_src1, 32'hFFFF_FFF9);
                check("div_signed", src_is_signed, 1'b1);
            end
            cyc();
        end
        divres_valid = 1'b1;
        alu_result   = 32'hFFFF_FFFD;
        #2;
        pulses += int'(alu_valid);
        check("div_handoff", es_to_ms_valid, 1'b1);
        check("div_handoff_allowin", es_allowin, 1'b1);
        check("div_fwd_res", es_fwd_result, 32'hFFFF_FFFD);
        check("div_fwd_ld_clear", es_fwd_is_load, 1'b0);
        cyc();
        divres_valid = 1'b0;
        alu_result   = '0;
        #2;
        check("div_after", es_to_ms_valid, 1'b0);
        check("div_alu_valid_pulses", pulses, 1);
        check("div_allowin_low_cycles", low, 10);

        // Unsigned mod completes while MEM stalls for 3 cycles: result must be held.
        pc = 32'h1c00_0200;
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = pack(pc, OP_MOD, 32'd100, 32'd7, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 2'b10, 32'h0);
        sb_q.push_back(es_exp(pc, 32'd2, 5'd6, 1'b1, 1'b0, 2'b10));
        cyc();
        ds_to_es_valid = 1'b0;
        alu_result     = 32'hDEAD_0000;
        #2;
        check("mod_alu_valid", alu_valid, 1'b1);
        for (int k = 0; k < 4; k++) cyc();
        divres_valid = 1'b1;
        ms_allowin   = 1'b0;
        alu_result   = 32'd2;
        #2;
        check("mod_stall_allowin", es_allowin, 1'b0);
        cyc();
        divres_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            alu_result = 32'hDEAD_0001 + 32'(k);
            #2;
            check("mod_done_valid", es_to_ms_valid, 1'b1);
            check("mod_done_fwd_res", es_fwd_result, 32'd2);
            check("mod_done_bus_res", es_to_ms_bus[40:9], 32'd2);
            check("mod_done_allowin", es_allowin, 1'b0);
            cyc();
        end
        ms_allowin = 1'b1;
        #2;
        check("mod_release_valid", es_to_ms_valid, 1'b1);
        check("mod_release_allowin", es_allowin, 1'b1);
        cyc();
        alu_result = '0;
        #2;
        check("mod_after", es_to_ms_valid, 1'b0);

        // Flush two cycles into a divide: drain the orphan result, then a normal add.
        pc = 32'h1c00_0300;
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = pack(pc, OP_DIV, 32'd50, 32'd5, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 2'b10, 32'h0);
        cyc();
        ds_to_es_valid = 1'b0;
        cyc();
        cyc();
        flush = 1'b1;
        #2;
        check("flush_no_handoff", es_to_ms_valid, 1'b0);
        cyc();
        flush          = 1'b0;
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = pack(pc + 4, OP_ADD, 32'd20, 32'd22, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 2'b10, 32'h0);
        sb_q.push_back(es_exp(pc + 4, 32'd42, 5'd7, 1'b1, 1'b0, 2'b10));
        for (int k = 0; k < 3; k++) begin
            #2;
            check("drain_allowin", es_allowin, 1'b0);
            check("drain_no_handoff", es_to_ms_valid, 1'b0);
            cyc();
        end
        divres_valid = 1'b1;
        alu_result   = 32'h77;
        #2;
        check("drain_res_allowin", es_allowin, 1'b0);
        check("drain_res_no_handoff", es_to_ms_valid, 1'b0);
        cyc();
        divres_valid = 1'b0;
        alu_result   = '0;
        #2;
        check("drain_released", es_allowin, 1'b1);
        cyc();
        ds_to_es_valid = 1'b0;
        alu_result     = 32'd42;
        #2;
        check("post_drain_add", es_to_ms_valid, 1'b1);
        check("post_drain_alu_valid", alu_valid, 1'b0);
        cyc();
        alu_result = '0;
        #2;
        check("post_drain_idle", es_to_ms_valid, 1'b0);

        // Flush on the divide-start cycle: the start still issues, stage drains.
        pc = 32'h1c00_0400;
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = pack(pc, OP_DIV, 32'd9, 32'd3, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 2'b10, 32'h0);
        cyc();
        ds_to_es_valid = 1'b0;
        flush          = 1'b1;
        #2;
        check("fstart_alu_valid", alu_valid, 1'b1);
        check("fstart_no_handoff", es_to_ms_valid, 1'b0);
        cyc();
        flush = 1'b0;
        #2;
        check("fstart_drain_allowin", es_allowin, 1'b0);
        check("fstart_no_restart", alu_valid, 1'b0);
        cyc();
        divres_valid = 1'b1;
        #2;
        check("fstart_res_allowin", es_allowin, 1'b0);
        cyc();
        divres_valid = 1'b0;
        #2;
        check("fstart_released", es_allowin, 1'b1);

        // Reset mid-divide, then a stray divres_valid must be ignored.
        pc = 32'h1c00_0500;
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = pack(pc, OP_DIV, 32'd8, 32'd2, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 2'b10, 32'h0);
        cyc();
        ds_to_es_valid = 1'b0;
        #2;
        check("rdiv_alu_valid", alu_valid, 1'b1);
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #2;
        check("rdiv_allowin", es_allowin, 1'b1);
        check("rdiv_to_ms", es_to_ms_valid, 1'b0);
        check("rdiv_alu_op", alu_op, '0);
        cyc();
        divres_valid = 1'b1;
        alu_result   = 32'h99;
        #2;
        check("stray_to_ms", es_to_ms_valid, 1'b0);
        check("stray_allowin", es_allowin, 1'b1);
        check("stray_alu_valid", alu_valid, 1'b0);
        cyc();
        divres_valid = 1'b0;
        alu_result   = '0;
        cyc();
        #2;
        check("sb_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
